// File: rtl/blift_sched.sv
// blift_sched
// Job scheduler for the fixed-point base-lift sum-of-products datapath.
// On an accepted go it walks coefficients 0..num_coeff-1, holding sum_start
// high for one 7-cycle slot per coefficient, and presents the share-memory
// read address. Results returned by the datapath are written to the result
// memory in coefficient order. At most MAX_OUT slots may be in flight.
//
// Parameters:
//   COEF_AW  coefficient index width
//   MAX_OUT  slots issued but not yet returned (1..15)
//   TIMEOUT  watchdog limit in cycles (watchdog builds only)
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   go             job start pulse, accepted in IDLE only
//   num_coeff      coefficient count, latched on accepted go
//   stall_req      pause request, honoured at slot boundaries
//   busy           high from accepted go through the done cycle
//   done           one-cycle pulse at job end
//   sum_start      datapath start level
//   share_rd_addr  {issue_idx[COEF_AW-1:0], share_idx[2:0]}
//   sop_in         datapath rounded sum
//   sop_valid      datapath result strobe
//   res_wr_en/addr/data  result memory write port (registered)
//   err_unexp      sticky: result strobe with nothing outstanding
//   err_timeout    sticky: watchdog fired (constant 0 without watchdog)
//
// Optional feature: define BLIFT_SCHED_WDOG_EN to enable the watchdog.

module blift_sched #(
  parameter int COEF_AW = 12,
  parameter int MAX_OUT = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 go,
  input  logic [COEF_AW:0]     num_coeff,
  input  logic                 stall_req,
  output logic                 busy,
  output logic                 done,
  output logic                 sum_start,
  output logic [COEF_AW+2:0]   share_rd_addr,
  input  logic [33:0]          sop_in,
  input  logic                 sop_valid,
  output logic                 res_wr_en,
  output logic [COEF_AW-1:0]   res_wr_addr,
  output logic [33:0]          res_wr_data,
  output logic                 err_unexp,
  output logic                 err_timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_PAUSE,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [3:0] MAX_OUT_V = 4'(MAX_OUT);

  state_t           state;
  state_t           state_nx;
  logic [COEF_AW:0] num_lat;
  logic [COEF_AW:0] issue_idx;
  logic [COEF_AW:0] issue_idx_nx;
  logic [COEF_AW:0] wr_idx;
  logic [3:0]       outstanding;
  logic [3:0]       out_nx;
  logic [2:0]       share_idx;
  logic             go_acc;
  logic             slot_end;
  logic             ret_ok;
  logic             wd_fire;

  assign go_acc   = (state == S_IDLE) && go;
  assign slot_end = (state == S_ISSUE) && (share_idx == 3'd6);
  assign ret_ok   = sop_valid && (outstanding != '0);

  assign issue_idx_nx = issue_idx + {{COEF_AW{1'b0}}, slot_end};

  // Slot-end increment and result decrement in one cycle cancel out.
  always_comb begin
    out_nx = outstanding;
    if (slot_end && !ret_ok)
      out_nx = outstanding + 4'd1;
    else if (!slot_end && ret_ok)
      out_nx = outstanding - 4'd1;
  end

`ifdef BLIFT_SCHED_WDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] wd_cnt;

  assign wd_fire = (wd_cnt == WD_W'(TIMEOUT)) &&
                   ((state == S_ISSUE) || (state == S_PAUSE) || (state == S_DRAIN));

  // Saturates at TIMEOUT so a late abort cannot wrap and re-arm silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      wd_cnt <= '0;
    else if (go_acc || sop_valid)
      wd_cnt <= '0;
    else if ((outstanding != '0) && (wd_cnt != WD_W'(TIMEOUT)))
      wd_cnt <= wd_cnt + WD_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_timeout <= 1'b0;
    else if (go_acc)
      err_timeout <= 1'b0;
    else if (wd_fire)
      err_timeout <= 1'b1;
  end
`else
  assign wd_fire     = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // Boundary decisions look at the post-update counters so the slot that
  // fills the window is the last one issued; PAUSE and DRAIN look at the
  // registered count, which puts done two cycles after the last result.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        // A zero-length job passes through DRAIN so busy spans two cycles.
        if (go)
          state_nx = (num_coeff == '0) ? S_DRAIN : S_ISSUE;
      end
      S_ISSUE: begin
        if (slot_end) begin
          if (issue_idx_nx == num_lat)
            state_nx = S_DRAIN;
          else if (stall_req || (out_nx == MAX_OUT_V))
            state_nx = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (!stall_req && (outstanding < MAX_OUT_V))
          state_nx = S_ISSUE;
      end
      S_DRAIN: begin
        if (outstanding == '0)
          state_nx = S_DONE;
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
    if (wd_fire)
      state_nx = S_DONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum_start <= 1'b0;
      share_idx <= '0;
    end else begin
      state     <= state_nx;
      busy      <= (state_nx != S_IDLE);
      done      <= (state_nx == S_DONE);
      sum_start <= (state_nx == S_ISSUE);
      // Counts only while a slot continues; entering or resuming starts at 0.
      if ((state == S_ISSUE) && (state_nx == S_ISSUE) && !slot_end)
        share_idx <= share_idx + 3'd1;
      else
        share_idx <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num_lat     <= '0;
      issue_idx   <= '0;
      wr_idx      <= '0;
      outstanding <= '0;
      err_unexp   <= 1'b0;
    end else if (go_acc) begin
      num_lat     <= num_coeff;
      issue_idx   <= '0;
      wr_idx      <= '0;
      outstanding <= '0;
      err_unexp   <= 1'b0;
    end else begin
      issue_idx   <= issue_idx_nx;
      outstanding <= out_nx;
      if (ret_ok)
        wr_idx <= wr_idx + {{COEF_AW{1'b0}}, 1'b1};
      if (sop_valid && !ret_ok)
        err_unexp <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_wr_en   <= 1'b0;
      res_wr_addr <= '0;
      res_wr_data <= '0;
    end else begin
      res_wr_en <= ret_ok;
      if (ret_ok) begin
        res_wr_addr <= wr_idx[COEF_AW-1:0];
        res_wr_data <= sop_in;
      end
    end
  end

  assign share_rd_addr = {issue_idx[COEF_AW-1:0], share_idx};

endmodule

// File: tb/tb_blift_sched.sv
// Testbench for blift_sched: job-level reference model plus datapath stand-in.
`timescale 1ns/1ps
module tb_blift_sched;

  localparam int AW   = 4;
  localparam int MAXO = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          go;
  logic [AW:0]   num_coeff;
  logic          stall_req;
  logic          busy;
  logic          done;
  logic          sum_start;
  logic [AW+2:0] share_rd_addr;
  logic [33:0]   sop_in;
  logic          sop_valid;
  logic          res_wr_en;
  logic [AW-1:0] res_wr_addr;
  logic [33:0]   res_wr_data;
  logic          err_unexp;
  logic          err_timeout;

  always #5 clk = ~clk;

  blift_sched #(.COEF_AW(AW), .MAX_OUT(MAXO), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst), .go(go), .num_coeff(num_coeff), .stall_req(stall_req),
    .busy(busy), .done(done), .sum_start(sum_start), .share_rd_addr(share_rd_addr),
    .sop_in(sop_in), .sop_valid(sop_valid), .res_wr_en(res_wr_en),
    .res_wr_addr(res_wr_addr), .res_wr_data(res_wr_data),
    .err_unexp(err_unexp), .err_timeout(err_timeout)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a job is n slots; outstanding is issued minus returned.
  int          m_n = 0;
  int          m_issued = 0;
  int          m_returned = 0;
  int          m_pos = -1;      // position within current slot, -1 when not issuing
  bit          m_active = 0;
  bit          m_drain = 0;
  bit          m_done = 0;
  bit          e_wr_en = 0;
  int          e_wr_addr = 0;
  logic [33:0] e_wr_data = '0;
  bit          e_err = 0;

  task automatic m_reset();
    m_n = 0; m_issued = 0; m_returned = 0; m_pos = -1;
    m_active = 0; m_drain = 0; m_done = 0;
    e_wr_en = 0; e_wr_addr = 0; e_wr_data = '0; e_err = 0;
  endtask

  task automatic m_step(input logic go_i, input int nc_i, input logic stall_i,
                        input logic sv_i, input logic [33:0] sin_i);
    int old_out;
    old_out = m_issued - m_returned;
    if (sv_i && old_out > 0) begin
      e_wr_en = 1; e_wr_addr = m_returned % (1 << AW); e_wr_data = sin_i;
      m_returned++;
    end else begin
      e_wr_en = 0;
    end
    if (sv_i && old_out == 0) e_err = 1;
    if (m_done) begin
      m_done = 0; m_active = 0;
    end else if (!m_active) begin
      if (go_i) begin
        m_active = 1; m_n = nc_i; m_issued = 0; m_returned = 0; e_err = 0;
        m_drain = (nc_i == 0);
        m_pos = (nc_i == 0) ? -1 : 0;
      end
    end else if (m_pos >= 0) begin
      if (m_pos == 6) begin
        m_issued++;
        if (m_issued == m_n) begin
          m_pos = -1; m_drain = 1;
        end else if (stall_i || (m_issued - m_returned) == MAXO) begin
          m_pos = -1;
        end else begin
          m_pos = 0;
        end
      end else begin
        m_pos++;
      end
    end else if (m_drain) begin
      if (old_out == 0) m_done = 1;
    end else if (!stall_i && old_out < MAXO) begin
      m_pos = 0;
    end
  endtask

  int cyc = 0;
  always @(posedge clk) begin
    if (rst) m_reset();
    else m_step(go, int'(num_coeff), stall_req, sop_valid, sop_in);
    cyc++;
  end

  // Datapath stand-in state and observation counters
  int due_q[$];
  int wr_addrs[$];
  int lat = 12;
  int dp_cnt = 0;
  bit spur_req = 0;
  int cnt_ss = 0, cnt_wr = 0, cnt_done = 0, cnt_busy = 0;
  int slot_ends = 0, sop_seen = 0, max_out = 0;

  always @(negedge clk) begin
    longint unsigned exp_sra;
    exp_sra = (longint'(m_issued % (1 << AW)) << 3) | longint'((m_pos < 0) ? 0 : m_pos);
    chk("busy", busy, m_active);
    chk("done", done, m_done);
    chk("sum_start", sum_start, (m_pos >= 0));
    chk("share_rd_addr", share_rd_addr, exp_sra);
    chk("res_wr_en", res_wr_en, e_wr_en);
    chk("res_wr_addr", res_wr_addr, e_wr_addr);
    chk("res_wr_data", res_wr_data, e_wr_data);
    chk("err_unexp", err_unexp, e_err);
    chk("err_timeout", err_timeout, 0);
    if (sum_start) begin
      cnt_ss++;
      if (dp_cnt == 6) begin
        dp_cnt = 0; slot_ends++; due_q.push_back(cyc + lat);
      end else begin
        dp_cnt++;
      end
    end else begin
      dp_cnt = 0;
    end
    if (sop_valid) sop_seen++;
    if (slot_ends - sop_seen > max_out) max_out = slot_ends - sop_seen;
    if (res_wr_en) begin cnt_wr++; wr_addrs.push_back(int'(res_wr_addr)); end
    if (done) cnt_done++;
    if (busy) cnt_busy++;
  end

  always @(posedge clk) begin
    #1;
    sop_in = {2'($urandom_range(0, 3)), 32'($urandom())};
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      void'(due_q.pop_front());
      sop_valid = 1'b1;
    end else begin
      sop_valid = spur_req;
    end
    spur_req = 0;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_counts();
    cnt_ss = 0; cnt_wr = 0; cnt_done = 0; cnt_busy = 0;
    slot_ends = 0; sop_seen = 0; max_out = 0;
    wr_addrs.delete();
  endtask

  task automatic wait_done(input int bound, input bit rnd);
    for (int k = 0; k < bound; k++) begin
      tick();
      go = 1'b0;
      if (cnt_done > 0) break;
      if (rnd) begin
        if ($urandom_range(0, 7) == 0) stall_req = ~stall_req;
        if ($urandom_range(0, 15) == 0) begin
          go = 1'b1;
          num_coeff = (AW + 1)'($urandom_range(0, 16));
        end
      end
    end
    go = 1'b0;
    stall_req = 1'b0;
  endtask

  task automatic run_job(input int nc, input bit rnd);
    clear_counts();
    num_coeff = (AW + 1)'(nc);
    go = 1'b1;
    tick();
    go = 1'b0;
    wait_done(4000, rnd);
    tick();
    tick();
  endtask

  initial begin
    rst = 1'b1; go = 1'b0; num_coeff = '0; stall_req = 1'b0;
    sop_valid = 1'b0; sop_in = '0;
    tick();
    chk("reset_busy", busy, 0);
    chk("reset_sum_start", sum_start, 0);
    chk("reset_share", share_rd_addr, 0);
    chk("reset_wr_en", res_wr_en, 0);
    chk("reset_wr_data", res_wr_data, 0);
    tick();
    rst = 1'b0;
    tick();

    // Three coefficients, no stall, 12-cycle datapath
    lat = 12;
    run_job(3, 0);
    chk("c3_sum_start_cycles", cnt_ss, 21);
    chk("c3_writes", cnt_wr, 3);
    for (int i = 0; i < 3; i++) chk("c3_addr", wr_addrs[i], i);
    chk("c3_done_pulses", cnt_done, 1);

    // Zero-length job
    run_job(0, 0);
    chk("c0_busy_cycles", cnt_busy, 2);
    chk("c0_done_pulses", cnt_done, 1);
    chk("c0_sum_start_cycles", cnt_ss, 0);
    chk("c0_writes", cnt_wr, 0);

    // Throttled by MAX_OUT with a slow datapath
    lat = 30;
    run_job(5, 0);
    chk("thr_max_outstanding", max_out, MAXO);
    chk("thr_writes", cnt_wr, 5);
    for (int i = 0; i < 5; i++) chk("thr_addr", wr_addrs[i], i);

    // Stall raised mid-slot 0
    lat = 5;
    clear_counts();
    num_coeff = 2;
    go = 1'b1;
    tick();
    go = 1'b0;
    tick(); tick(); tick();
    stall_req = 1'b1;
    repeat (20) tick();
    chk("stall_slot0_cycles", cnt_ss, 7);
    stall_req = 1'b0;
    wait_done(200, 0);
    chk("stall_total_cycles", cnt_ss, 14);
    chk("stall_done", cnt_done, 1);
    tick();

    // Spurious result strobe while idle
    clear_counts();
    spur_req = 1;
    tick(); tick(); tick();
    chk("spur_err", err_unexp, 1);
    chk("spur_writes", cnt_wr, 0);
    run_job(1, 0);
    chk("spur_cleared", err_unexp, 0);

    // Reset in the middle of a long job
    lat = 8;
    clear_counts();
    num_coeff = 10;
    go = 1'b1;
    tick();
    go = 1'b0;
    repeat (20) tick();
    rst = 1'b1;
    m_reset();
    due_q.delete();
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_sum_start", sum_start, 0);
    chk("midrst_share", share_rd_addr, 0);
    chk("midrst_wr_en", res_wr_en, 0);
    chk("midrst_wr_addr", res_wr_addr, 0);
    tick(); tick();
    rst = 1'b0;
    tick();
    run_job(1, 0);
    chk("postrst_writes", cnt_wr, 1);
    chk("postrst_addr", wr_addrs[0], 0);

    // Full address range: write address wraps into the index MSB
    lat = 3;
    run_job(16, 0);
    chk("c16_writes", cnt_wr, 16);
    chk("c16_last_addr", wr_addrs[15], 15);
    chk("c16_share_after", share_rd_addr, 0);

    // Randomized jobs with stalls, ignored go pulses and idle strobes
    for (int j = 0; j < 25; j++) begin
      int nc;
      nc = $urandom_range(0, 12);
      lat = $urandom_range(1, 40);
      run_job(nc, 1);
      chk("rnd_done", cnt_done, 1);
      chk("rnd_writes", cnt_wr, nc);
      if ($urandom_range(0, 3) == 0) begin
        spur_req = 1;
        tick(); tick();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
